// File: rtl/mips_pkg.sv
// Shared MEM-stage types: access size codes, load lane bundle and FSM encoding.
// Imported by the MEM stage and its load alignment helper.
package mips_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10
    } mem_state_t;

    typedef struct packed {
        logic [1:0] lane;
        logic [1:0] size;
        logic       is_unsigned;
    } load_lane_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (size == MEM_BYTE): bad = 1'b0;
            (size == MEM_HALF): bad = addr_lo[0];
            default:            bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            (size == MEM_BYTE): be = 4'b0001 << addr_lo;
            (size == MEM_HALF): be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:            be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed byte/half from a read word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {lane, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        unique case (1'b1)
            (size == MEM_BYTE):
                data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            (size == MEM_HALF):
                data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:
                data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data memory req/gnt/rvalid port, stalls upstream
// until each access completes and presents write-back operands to MEM_WB.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         Reg_Write_in,
    input  logic         MemtoReg_in,
    input  logic         MemRead_in,
    input  logic         MemWrite_in,
    input  logic [1:0]   mem_size_in,
    input  logic         mem_unsigned_in,
    input  logic [n-1:0] ALU_Output_in,
    input  logic [n-1:0] write_data_in,
    input  logic [4:0]   EX_MEM_Rd_in,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [n-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [n-1:0] dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [n-1:0] dmem_rdata,
    output logic         stall_out,
    output logic         misaligned_out,
    output logic         Reg_Write_out,
    output logic         MemtoReg_out,
    output logic [n-1:0] data_memory_output_out,
    output logic [n-1:0] ALU_Output_to_MUX_out,
    output logic [4:0]   MEM_WB_Rd_in_out
);

    mem_state_t state, state_next;
    load_lane_t lane_q;
    logic       lane_load;
    logic       mem_op;
    logic       misaligned;
    logic       completing;
    logic [n-1:0] aligned;

    assign mem_op     = MemRead_in | MemWrite_in;
    assign misaligned = mem_op & is_misaligned(mem_size_in, ALU_Output_in[1:0]);

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state  <= IDLE;
            lane_q <= '0;
        end else begin
            state <= state_next;
            if (lane_load) begin
                lane_q.lane        <= ALU_Output_in[1:0];
                lane_q.size        <= mem_size_in;
                lane_q.is_unsigned <= mem_unsigned_in;
            end
        end
    end

    always_comb begin
        state_next     = state;
        dmem_req       = 1'b0;
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        lane_load      = 1'b0;
        completing     = 1'b0;
        unique case (state)
            IDLE, REQ: begin
                if (misaligned) begin
                    misaligned_out = 1'b1;
                    state_next     = IDLE;
                end else if (mem_op) begin
                    dmem_req = 1'b1;
                    if (!dmem_gnt) begin
                        state_next = REQ;
                        stall_out  = 1'b1;
                    end else if (MemWrite_in) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_R;
                        stall_out  = 1'b1;
                        lane_load  = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    completing = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset dominates: drop any request and keep MEM_WB quiet.
        if (reset_in) begin
            dmem_req       = 1'b0;
            stall_out      = 1'b0;
            misaligned_out = 1'b0;
            lane_load      = 1'b0;
            completing     = 1'b0;
        end
    end

    assign dmem_we   = MemWrite_in;
    assign dmem_addr = {ALU_Output_in[n-1:2], 2'b00};
    assign dmem_be   = MemWrite_in
                     ? store_be(mem_size_in, ALU_Output_in[1:0])
                     : 4'b1111;

    always_comb begin
        dmem_wdata = write_data_in;
        unique case (1'b1)
            (mem_size_in == MEM_BYTE): dmem_wdata = {4{write_data_in[7:0]}};
            (mem_size_in == MEM_HALF): dmem_wdata = {2{write_data_in[15:0]}};
            default:                   dmem_wdata = write_data_in;
        endcase
    end

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .lane        (lane_q.lane),
        .size        (lane_q.size),
        .is_unsigned (lane_q.is_unsigned),
        .data        (aligned)
    );

    assign Reg_Write_out = Reg_Write_in & ~stall_out
                         & ~misaligned_out & ~reset_in;
    assign MemtoReg_out           = MemtoReg_in;
    assign ALU_Output_to_MUX_out  = ALU_Output_in;
    assign MEM_WB_Rd_in_out       = EX_MEM_Rd_in;
    assign data_memory_output_out = completing ? aligned : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for the MEM stage: pass-through, stores, loads
// with wait states, misalignment, reset mid-access and back-to-back ops.
module tb_mem_access_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        Reg_Write_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] ALU_Output_in, write_data_in;
    logic [4:0]  EX_MEM_Rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out, misaligned_out;
    logic        Reg_Write_out, MemtoReg_out;
    logic [31:0] data_memory_output_out, ALU_Output_to_MUX_out;
    logic [4:0]  MEM_WB_Rd_in_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.n(32)) dut (
        .clk                    (clk),
        .reset_in               (reset_in),
        .Reg_Write_in           (Reg_Write_in),
        .MemtoReg_in            (MemtoReg_in),
        .MemRead_in             (MemRead_in),
        .MemWrite_in            (MemWrite_in),
        .mem_size_in            (mem_size_in),
        .mem_unsigned_in        (mem_unsigned_in),
        .ALU_Output_in          (ALU_Output_in),
        .write_data_in          (write_data_in),
        .EX_MEM_Rd_in           (EX_MEM_Rd_in),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_be                (dmem_be),
        .dmem_wdata             (dmem_wdata),
        .dmem_gnt               (dmem_gnt),
        .dmem_rvalid            (dmem_rvalid),
        .dmem_rdata             (dmem_rdata),
        .stall_out              (stall_out),
        .misaligned_out         (misaligned_out),
        .Reg_Write_out          (Reg_Write_out),
        .MemtoReg_out           (MemtoReg_out),
        .data_memory_output_out (data_memory_output_out),
        .ALU_Output_to_MUX_out  (ALU_Output_to_MUX_out),
        .MEM_WB_Rd_in_out       (MEM_WB_Rd_in_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rdst, input logic rw);
        MemRead_in      = rd;
        MemWrite_in     = wr;
        mem_size_in     = size;
        mem_unsigned_in = uns;
        ALU_Output_in   = addr;
        write_data_in   = wd;
        EX_MEM_Rd_in    = rdst;
        Reg_Write_in    = rw;
        MemtoReg_in     = rd;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Load with gnt on cycle g and rvalid on cycle v (v > g).
    task automatic run_load(input string tag, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input int g, input int v,
                            input logic [31:0] rdata,
                            input logic [31:0] exp);
        set_op(1'b1, 1'b0, size, uns, addr, 32'h0, 5'd9, 1'b1);
        dmem_rdata = rdata;
        for (int c = 0; c <= v; c++) begin
            dmem_gnt    = (c == g);
            dmem_rvalid = (c == v);
            @(negedge clk);
            chk({tag, "_stall"}, 32'(stall_out), 32'(c < v));
            chk({tag, "_req"}, 32'(dmem_req), 32'(c <= g));
            chk({tag, "_rw"}, 32'(Reg_Write_out), 32'(c == v));
            if (c == v) chk({tag, "_data"}, data_memory_output_out, exp);
            next_cycle();
        end
        nop();
    endtask

    initial begin
        nop();
        reset_in = 1'b1;
        // Misaligned LW with RegWrite during reset: everything stays quiet.
        set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h106, 32'h0, 5'd3, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rw", 32'(Reg_Write_out), 32'd0);
        chk("rst_misal", 32'(misaligned_out), 32'd0);
        next_cycle();
        reset_in = 1'b0;
        nop();

        // 1. Non-memory ALU op passes straight through.
        set_op(1'b0, 1'b0, MEM_WORD, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        chk("alu_out", ALU_Output_to_MUX_out, 32'h0000_1234);
        chk("alu_rd", 32'(MEM_WB_Rd_in_out), 32'd5);
        chk("alu_rw", 32'(Reg_Write_out), 32'd1);
        chk("alu_stall", 32'(stall_out), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_data", data_memory_output_out, 32'h0);
        next_cycle();

        // 2. SB to 0x103, granted immediately.
        set_op(1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h103, 32'hAABBCCDD, 5'd0, 1'b0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("sb_req", 32'(dmem_req), 32'd1);
        chk("sb_we", 32'(dmem_we), 32'd1);
        chk("sb_be", 32'(dmem_be), 32'b1000);
        chk("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_stall", 32'(stall_out), 32'd0);
        next_cycle();
        nop();

        // 3. LB / LBU at 0x101 with two wait cycles for gnt.
        set_op(1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        chk("lb_be", 32'(dmem_be), 32'hF);
        chk("lb_addr", dmem_addr, 32'h100);
        run_load("lb", MEM_BYTE, 1'b0, 32'h101, 2, 5, 32'h1122_8344,
                 32'hFFFF_FF83);
        run_load("lbu", MEM_BYTE, 1'b1, 32'h101, 2, 5, 32'h1122_8344,
                 32'h0000_0083);

        // 4. LH at 0x102, then misaligned LW at 0x106.
        run_load("lh", MEM_HALF, 1'b0, 32'h102, 0, 1, 32'h8001_7FFF,
                 32'hFFFF_8001);
        set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h106, 32'h0, 5'd4, 1'b1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("mis_flag", 32'(misaligned_out), 32'd1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall_out), 32'd0);
        chk("mis_rw", 32'(Reg_Write_out), 32'd0);
        next_cycle();
        nop();

        // 5. Reset while waiting for read data; late rvalid ignored.
        set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1);
        dmem_gnt = 1'b1;
        next_cycle();
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(stall_out), 32'd1);
        next_cycle();
        reset_in = 1'b1;
        @(negedge clk);
        chk("rw_rst_stall", 32'(stall_out), 32'd0);
        chk("rw_rst_req", 32'(dmem_req), 32'd0);
        next_cycle();
        reset_in = 1'b0;
        nop();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("late_stall", 32'(stall_out), 32'd0);
        chk("late_rw", 32'(Reg_Write_out), 32'd0);
        chk("late_data", data_memory_output_out, 32'h0);
        next_cycle();
        nop();

        // 6. Back-to-back SW then LW with gnt held high.
        dmem_gnt = 1'b1;
        set_op(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h200, 32'h1357_9BDF, 5'd0, 1'b0);
        @(negedge clk);
        chk("sw_req", 32'(dmem_req), 32'd1);
        chk("sw_we", 32'(dmem_we), 32'd1);
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'h1357_9BDF);
        chk("sw_stall", 32'(stall_out), 32'd0);
        next_cycle();
        set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h204, 32'h0, 5'd8, 1'b1);
        @(negedge clk);
        chk("lw_req0", 32'(dmem_req), 32'd1);
        chk("lw_we0", 32'(dmem_we), 32'd0);
        chk("lw_stall0", 32'(stall_out), 32'd1);
        next_cycle();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("lw_req1", 32'(dmem_req), 32'd0);
        chk("lw_stall1", 32'(stall_out), 32'd0);
        chk("lw_rw1", 32'(Reg_Write_out), 32'd1);
        chk("lw_data", data_memory_output_out, 32'hCAFE_F00D);
        next_cycle();
        nop();
        @(negedge clk);
        chk("end_req", 32'(dmem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
